// File: rtl/index_adder_pkg.sv
// Shared types and defaults for the index-adder arbiter: FSM state encoding,
// default widths and the round-robin slot helper.
package index_adder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam int DEFAULT_NREQ    = 4;
   localparam int DEFAULT_W       = 8;
   localparam int DEFAULT_TIMEOUT = 8;

   // Requester index visited at a given offset after the previous winner.
   function automatic int rr_slot(input int last, input int offset, input int n);
      return (last + offset) % n;
   endfunction

endpackage

// File: rtl/index_adder_arbiter_rr.sv
// Combinational round-robin pick: the first requester after last_grant wins,
// so the previous winner is always considered last.
module rr_arbiter
   import index_adder_pkg::*;
#(
   parameter int NREQ = DEFAULT_NREQ,
   parameter int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
)(
   input  logic [NREQ-1:0] req,
   input  logic [GW-1:0]   last_grant,
   output logic [NREQ-1:0] grant_oh,
   output logic [GW-1:0]   grant_idx,
   output logic            any_req
);

   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      any_req   = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!any_req && req[rr_slot(int'(last_grant), k, NREQ)]) begin
            any_req = 1'b1;
            grant_oh[rr_slot(int'(last_grant), k, NREQ)] = 1'b1;
            grant_idx = GW'(rr_slot(int'(last_grant), k, NREQ));
         end
      end
   end

endmodule

// File: rtl/index_adder_arbiter.sv
// Shares one pipelined index adder among NREQ requesters, one operation in
// flight, with a watchdog that answers with an error if the adder never replies.
module index_adder_arbiter
   import index_adder_pkg::*;
#(
   parameter int NREQ    = DEFAULT_NREQ,
   parameter int W       = DEFAULT_W,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
)(
   input  logic              clk,
   input  logic              resetn,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   rsp_valid,
   input  logic [NREQ-1:0]   rsp_ready,
   output logic [W-1:0]      rsp_s,
   output logic              rsp_err,
   output logic              add_ce,
   output logic [W-1:0]      add_a,
   output logic [W-1:0]      add_b,
   input  logic              add_valid,
   input  logic [W-1:0]      add_s
);

   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int DW = $clog2(TIMEOUT + 1);
   localparam logic [GW-1:0] LAST_INIT = GW'(NREQ - 1);

   state_t          state, state_nxt;
   logic [GW-1:0]   grant, last_grant, arb_idx;
   logic [NREQ-1:0] arb_oh, grant_oh;
   logic            arb_any;
   logic [W-1:0]    op_a, op_b, result;
   logic            err;
   logic [DW-1:0]   wdog;
   logic            wdog_expired;
   logic            rsp_fire;

   rr_arbiter #(.NREQ(NREQ), .GW(GW)) u_arb (
      .req        (req_valid),
      .last_grant (last_grant),
      .grant_oh   (arb_oh),
      .grant_idx  (arb_idx),
      .any_req    (arb_any)
   );

   always_comb begin
      grant_oh        = '0;
      grant_oh[grant] = 1'b1;
   end

   assign wdog_expired = (wdog == DW'(TIMEOUT - 1));
   assign rsp_fire     = rsp_ready[grant];
   assign add_a        = op_a;
   assign add_b        = op_b;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // last_grant starts at NREQ-1 so requester 0 is first in line after reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         grant      <= '0;
         last_grant <= LAST_INIT;
         op_a       <= '0;
         op_b       <= '0;
         result     <= '0;
         err        <= 1'b0;
         wdog       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_any) begin
                  grant <= arb_idx;
                  op_a  <= req_a[arb_idx*W +: W];
                  op_b  <= req_b[arb_idx*W +: W];
               end
            end
            ISSUE: wdog <= '0;
            WAIT: begin
               if (add_valid) begin
                  result <= add_s;
                  err    <= 1'b0;
               end else if (wdog_expired) begin
                  result <= '0;
                  err    <= 1'b1;
               end else begin
                  wdog <= wdog + 1'b1;
               end
            end
            RESP: if (rsp_fire) last_grant <= grant;
            default: ;
         endcase
      end
   end

   // add_valid is only looked at in WAIT; stray strobes elsewhere are dropped.
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      rsp_valid = '0;
      rsp_s     = '0;
      rsp_err   = 1'b0;
      add_ce    = 1'b0;
      case (state)
         IDLE: begin
            if (arb_any) begin
               req_ready = arb_oh;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            add_ce    = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: if (add_valid || wdog_expired) state_nxt = RESP;
         RESP: begin
            rsp_valid = grant_oh;
            rsp_s     = result;
            rsp_err   = err;
            if (rsp_fire) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_index_adder_arbiter.sv
// Bench for index_adder_arbiter: directed vector table, multi-cycle corner
// sequences and a randomized run against a transaction-level reference model.
module tb_index_adder_arbiter;
   import index_adder_pkg::*;

   localparam int NREQ    = 4;
   localparam int W       = 8;
   localparam int TIMEOUT = 8;

   logic              clk = 1'b0;
   logic              resetn;
   logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
   logic [NREQ*W-1:0] req_a, req_b;
   logic [W-1:0]      rsp_s, add_a, add_b, add_s;
   logic              rsp_err, add_ce, add_valid;

   logic              dead, stray;
   logic              mdl_valid;
   logic [W-1:0]      mdl_s;

   int checks = 0;
   int errors = 0;

   index_adder_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_s     (rsp_s),
      .rsp_err   (rsp_err),
      .add_ce    (add_ce),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_valid (add_valid),
      .add_s     (add_s)
   );

   always #5 clk = ~clk;

   // One-cycle adder; "dead" silences it so only the stray strobe can show up.
   always @(posedge clk) begin
      mdl_valid <= add_ce;
      mdl_s     <= add_a + add_b;
   end
   assign add_valid = dead ? stray : mdl_valid;
   assign add_s     = mdl_s;

   typedef struct {
      int         idx;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] s;
   } vec_t;

   vec_t vecs[5];

   function automatic logic [NREQ-1:0] onehot(input int i);
      logic [NREQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic setOperands(input int i, input logic [7:0] a, input logic [7:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   task automatic applyStimulus(input int i, input logic [7:0] a, input logic [7:0] b);
      setOperands(i, a, b);
      req_valid = onehot(i);
   endtask

   task automatic doReset;
      resetn    = 1'b0;
      req_valid = '0;
      rsp_ready = '0;
      req_a     = '0;
      req_b     = '0;
      dead      = 1'b0;
      stray     = 1'b0;
      repeat (2) tick;
      resetn = 1'b1;
   endtask

   // Reference-model state for the randomized run.
   logic [NREQ-1:0] pending;
   logic [7:0]      pa[NREQ];
   logic [7:0]      pb[NREQ];
   int              m_last, m_cur, m_age, m_win;
   bit              m_busy;
   logic [7:0]      m_sum;
   logic [NREQ-1:0] exp_ready, exp_rv;

   initial begin
      int n, gcount, cyc, last_gcyc;

      vecs[0] = '{idx: 0, a: 8'h12, b: 8'h34, s: 8'h46};
      vecs[1] = '{idx: 2, a: 8'hFF, b: 8'h01, s: 8'h00};
      vecs[2] = '{idx: 1, a: 8'h80, b: 8'h80, s: 8'h00};
      vecs[3] = '{idx: 3, a: 8'h7F, b: 8'h01, s: 8'h80};
      vecs[4] = '{idx: 1, a: 8'hAA, b: 8'h55, s: 8'hFF};

      doReset;
      resetn = 1'b0;
      settle;
      checkOutput("reset_req_ready", req_ready, 0);
      checkOutput("reset_rsp_valid", rsp_valid, 0);
      checkOutput("reset_add_ce", add_ce, 0);
      checkOutput("reset_add_a", add_a, 0);
      checkOutput("reset_add_b", add_b, 0);
      checkOutput("reset_rsp_s", rsp_s, 0);
      checkOutput("reset_rsp_err", rsp_err, 0);
      tick;
      resetn = 1'b1;

      for (int v = 0; v < 5; v++) begin
         applyStimulus(vecs[v].idx, vecs[v].a, vecs[v].b);
         settle;
         checkOutput("vec_req_ready", req_ready, onehot(vecs[v].idx));
         tick;
         req_valid = '0;
         settle;
         checkOutput("vec_add_ce_pulse", add_ce, 1);
         checkOutput("vec_add_a", add_a, vecs[v].a);
         checkOutput("vec_add_b", add_b, vecs[v].b);
         checkOutput("vec_rsp_early", rsp_valid, 0);
         tick;
         settle;
         checkOutput("vec_add_ce_low", add_ce, 0);
         checkOutput("vec_rsp_wait", rsp_valid, 0);
         tick;
         settle;
         checkOutput("vec_rsp_valid", rsp_valid, onehot(vecs[v].idx));
         checkOutput("vec_rsp_s", rsp_s, vecs[v].s);
         checkOutput("vec_rsp_err", rsp_err, 0);
         rsp_ready = onehot(vecs[v].idx);
         tick;
         rsp_ready = '0;
         settle;
         checkOutput("vec_rsp_done", rsp_valid, 0);
      end

      // Backpressure on requester 1 while everyone else keeps asking.
      applyStimulus(1, 8'h05, 8'h06);
      settle;
      checkOutput("bp_grant", req_ready, onehot(1));
      tick;
      req_valid = '1;
      tick;
      tick;
      rsp_ready = 4'b1101;
      for (int c = 0; c < 5; c++) begin
         settle;
         checkOutput("bp_rsp_valid", rsp_valid, onehot(1));
         checkOutput("bp_rsp_s", rsp_s, 8'h0B);
         checkOutput("bp_no_ready", req_ready, 0);
         tick;
      end
      rsp_ready = onehot(1);
      tick;
      rsp_ready = '0;
      settle;
      checkOutput("bp_idle_after_release", req_ready, onehot(2));
      checkOutput("bp_rsp_cleared", rsp_valid, 0);
      req_valid = '0;
      tick;
      settle;
      checkOutput("bp_no_issue", add_ce, 0);

      // Watchdog: the adder never answers.
      dead = 1'b1;
      applyStimulus(3, 8'h01, 8'h02);
      settle;
      checkOutput("to_grant", req_ready, onehot(3));
      n = 0;
      do begin
         tick;
         req_valid = '0;
         settle;
         n++;
      end while (rsp_valid == '0 && n < 40);
      checkOutput("to_latency", n, TIMEOUT + 2);
      checkOutput("to_rsp_valid", rsp_valid, onehot(3));
      checkOutput("to_rsp_err", rsp_err, 1);
      checkOutput("to_rsp_s", rsp_s, 0);
      rsp_ready = onehot(3);
      tick;
      rsp_ready = '0;

      // Asynchronous reset in the middle of WAIT, then a stray add_valid.
      applyStimulus(2, 8'h21, 8'h43);
      settle;
      checkOutput("rw_grant", req_ready, onehot(2));
      tick;
      req_valid = '0;
      tick;
      tick;
      #3;
      resetn = 1'b0;
      #1;
      checkOutput("rw_add_a", add_a, 0);
      checkOutput("rw_add_b", add_b, 0);
      checkOutput("rw_add_ce", add_ce, 0);
      checkOutput("rw_rsp_valid", rsp_valid, 0);
      checkOutput("rw_rsp_err", rsp_err, 0);
      tick;
      resetn = 1'b1;
      stray  = 1'b1;
      for (int c = 0; c < 3; c++) begin
         settle;
         checkOutput("rw_stray_rsp", rsp_valid, 0);
         checkOutput("rw_stray_ce", add_ce, 0);
         tick;
      end
      stray = 1'b0;
      dead  = 1'b0;

      // Round-robin with everyone requesting and responses always taken.
      for (int i = 0; i < NREQ; i++) setOperands(i, 8'(8'h10 * i + 1), 8'h20);
      req_valid = '1;
      rsp_ready = '1;
      gcount    = 0;
      cyc       = 0;
      last_gcyc = 0;
      while (gcount < 8 && cyc < 200) begin
         settle;
         if (req_ready != '0) begin
            checkOutput("rr_order", req_ready, onehot(gcount % NREQ));
            if (gcount > 0) checkOutput("rr_spacing", cyc - last_gcyc, 4);
            last_gcyc = cyc;
            gcount++;
         end
         for (int i = 0; i < NREQ; i++)
            if (rsp_valid[i]) checkOutput("rr_rsp_s", rsp_s, 8'(8'h10 * i + 1 + 8'h20));
         tick;
         cyc++;
      end
      checkOutput("rr_grant_count", gcount, 8);

      // Randomized traffic against a transaction-level model.
      doReset;
      pending = '0;
      m_last  = NREQ - 1;
      m_busy  = 1'b0;
      m_cur   = 0;
      m_age   = 0;
      m_sum   = '0;
      for (int i = 0; i < NREQ; i++) begin
         pa[i] = '0;
         pb[i] = '0;
      end
      for (int c = 0; c < 600; c++) begin
         settle;
         exp_ready = '0;
         m_win     = -1;
         if (!m_busy && pending != '0) begin
            for (int k = 1; k <= NREQ; k++) begin
               if (m_win < 0 && pending[(m_last + k) % NREQ]) m_win = (m_last + k) % NREQ;
            end
            exp_ready = onehot(m_win);
         end
         checkOutput("rnd_req_ready", req_ready, exp_ready);
         exp_rv = (m_busy && m_age >= 3) ? onehot(m_cur) : '0;
         checkOutput("rnd_rsp_valid", rsp_valid, exp_rv);
         if (exp_rv != '0) begin
            checkOutput("rnd_rsp_s", rsp_s, m_sum);
            checkOutput("rnd_rsp_err", rsp_err, 0);
         end
         if (m_win >= 0) begin
            m_busy         = 1'b1;
            m_cur          = m_win;
            m_sum          = pa[m_win] + pb[m_win];
            m_age          = 1;
            pending[m_win] = 1'b0;
         end else if (m_busy) begin
            if (m_age >= 3 && rsp_ready[m_cur]) begin
               m_busy = 1'b0;
               m_last = m_cur;
            end else begin
               m_age++;
            end
         end
         tick;
         for (int i = 0; i < NREQ; i++) begin
            if (!pending[i] && $urandom_range(0, 2) == 0) begin
               pending[i] = 1'b1;
               pa[i]      = 8'($urandom);
               pb[i]      = 8'($urandom);
            end
            setOperands(i, pa[i], pb[i]);
         end
         req_valid = pending;
         rsp_ready = NREQ'($urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
